// File: rtl/dft_peak_scan.sv
// Scans the DFT amplitude memory for the largest bin, counting bins above a threshold and NaN bins.
// Optional DFT_PEAK_TOP2_EN adds tracking of the second-largest bin.
module dft_peak_scan #(
    parameter int N_BINS  = 128,
    parameter int ADDR_W  = 7,
    parameter int SKIP_DC = 1,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic              dft_done,
    input  logic [31:0]       thresh_in,
    input  logic [31:0]       ampl_in,
    output logic [ADDR_W-1:0] ampl_number,
    output logic              busy,
    output logic              peak_valid,
    output logic              abort,
    output logic [31:0]       peak_value,
    output logic [ADDR_W-1:0] peak_index,
    output logic [CNT_W-1:0]  above_count,
`ifdef DFT_PEAK_TOP2_EN
    output logic [31:0]       second_value,
    output logic [ADDR_W-1:0] second_index,
`endif
    output logic [CNT_W-1:0]  nan_count
);

    localparam logic [ADDR_W-1:0] FIRST   = (SKIP_DC != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N_BINS - 1);
    localparam logic [ADDR_W-1:0] LAST_M1 = ADDR_W'(N_BINS - 2);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    state_t              state;
    logic [31:0]         thresh;
    logic [31:0]         work_peak;
    logic [ADDR_W-1:0]   work_index;
    logic [CNT_W-1:0]    work_above;
    logic [CNT_W-1:0]    work_nan;
`ifdef DFT_PEAK_TOP2_EN
    logic [31:0]         work_second;
    logic [ADDR_W-1:0]   work_second_index;
    logic                new_second;
`endif

    logic        eval_en;
    logic        sample_ok;
    logic [31:0] sample_mag;
    logic        above;
    logic        new_peak;

    // ampl_in is the upstream combinational read of the address presented this cycle,
    // so the bin being evaluated is the current ampl_number.
    always_comb begin
        eval_en    = ((state == SCAN) || (state == FLUSH)) && dft_done;
        sample_ok  = !is_nan(ampl_in) && !ampl_in[31];
        sample_mag = {1'b0, ampl_in[30:0]};
        above      = sample_ok && (sample_mag > thresh);
        new_peak   = sample_ok && (sample_mag > work_peak);
`ifdef DFT_PEAK_TOP2_EN
        new_second = sample_ok && !new_peak && (sample_mag > work_second);
`endif
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            ampl_number <= '0;
            busy        <= 1'b0;
            peak_valid  <= 1'b0;
            abort       <= 1'b0;
            peak_value  <= '0;
            peak_index  <= '0;
            above_count <= '0;
            nan_count   <= '0;
            thresh      <= '0;
            work_peak   <= '0;
            work_index  <= '0;
            work_above  <= '0;
            work_nan    <= '0;
`ifdef DFT_PEAK_TOP2_EN
            second_value      <= '0;
            second_index      <= '0;
            work_second       <= '0;
            work_second_index <= '0;
`endif
        end else begin
            peak_valid <= 1'b0;
            abort      <= 1'b0;

            if (eval_en) begin
                if (is_nan(ampl_in)) work_nan <= sat_inc(work_nan);
                if (above) work_above <= sat_inc(work_above);
                if (new_peak) begin
                    work_peak  <= sample_mag;
                    work_index <= ampl_number;
`ifdef DFT_PEAK_TOP2_EN
                    work_second       <= work_peak;
                    work_second_index <= work_index;
`endif
                end
`ifdef DFT_PEAK_TOP2_EN
                else if (new_second) begin
                    work_second       <= sample_mag;
                    work_second_index <= ampl_number;
                end
`endif
            end

            case (state)
                IDLE: begin
                    if (start && dft_done) begin
                        state       <= (FIRST == LAST) ? FLUSH : SCAN;
                        busy        <= 1'b1;
                        ampl_number <= FIRST;
                        thresh      <= thresh_in & 32'h7FFF_FFFF;
                        work_peak   <= '0;
                        work_index  <= FIRST;
                        work_above  <= '0;
                        work_nan    <= '0;
`ifdef DFT_PEAK_TOP2_EN
                        work_second       <= '0;
                        work_second_index <= FIRST;
`endif
                    end
                end
                SCAN: begin
                    if (!dft_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        abort <= 1'b1;
                    end else begin
                        ampl_number <= ampl_number + 1'b1;
                        if (ampl_number == LAST_M1) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!dft_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        abort <= 1'b1;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    peak_value  <= work_peak;
                    peak_index  <= work_index;
                    above_count <= work_above;
                    nan_count   <= work_nan;
`ifdef DFT_PEAK_TOP2_EN
                    second_value <= work_second;
                    second_index <= work_second_index;
`endif
                    peak_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dft_peak_scan.sv
// Directed bench for dft_peak_scan: one instance with DC skipped, one scanning from bin 0,
// both reading a shared amplitude memory model.
module tb_dft_peak_scan;

    logic        clk;
    logic        n_reset;
    logic        start;
    logic        dft_done;
    logic [31:0] thresh_in;
    logic [31:0] mem [128];

    logic [31:0] ampl_in1, ampl_in0;
    logic [6:0]  ampl_number1, ampl_number0;
    logic        busy1, busy0, peak_valid1, peak_valid0, abort1, abort0;
    logic [31:0] peak_value1, peak_value0;
    logic [6:0]  peak_index1, peak_index0;
    logic [7:0]  above_count1, above_count0, nan_count1, nan_count0;
`ifdef DFT_PEAK_TOP2_EN
    logic [31:0] second_value1, second_value0;
    logic [6:0]  second_index1, second_index0;
`endif

    int n_vec = 0;
    int n_err = 0;

    assign ampl_in1 = mem[ampl_number1];
    assign ampl_in0 = mem[ampl_number0];

    dft_peak_scan #(.N_BINS(128), .ADDR_W(7), .SKIP_DC(1), .CNT_W(8)) dut1 (
        .clk(clk), .n_reset(n_reset), .start(start), .dft_done(dft_done),
        .thresh_in(thresh_in), .ampl_in(ampl_in1), .ampl_number(ampl_number1),
        .busy(busy1), .peak_valid(peak_valid1), .abort(abort1),
        .peak_value(peak_value1), .peak_index(peak_index1), .above_count(above_count1),
`ifdef DFT_PEAK_TOP2_EN
        .second_value(second_value1), .second_index(second_index1),
`endif
        .nan_count(nan_count1)
    );

    dft_peak_scan #(.N_BINS(128), .ADDR_W(7), .SKIP_DC(0), .CNT_W(8)) dut0 (
        .clk(clk), .n_reset(n_reset), .start(start), .dft_done(dft_done),
        .thresh_in(thresh_in), .ampl_in(ampl_in0), .ampl_number(ampl_number0),
        .busy(busy0), .peak_valid(peak_valid0), .abort(abort0),
        .peak_value(peak_value0), .peak_index(peak_index0), .above_count(above_count0),
`ifdef DFT_PEAK_TOP2_EN
        .second_value(second_value0), .second_index(second_index0),
`endif
        .nan_count(nan_count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] i2f(input int k);
        int p;
        logic [31:0] m;
        if (k == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 31; i++) if (((k >> i) & 1) == 1) p = i;
        m = (32'(k) << (23 - p)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 128; i++) mem[i] = i2f(i);
    endtask

    // Pulses start across one edge (E0) and samples just after it.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs 200 edges after E0, recording first peak_valid edge, pulse counts and busy cycles.
    task automatic run_scan(input int restart_at, output int l1, output int l0,
                            output int c1, output int c0, output int b1, output int b0);
        l1 = -1; l0 = -1; c1 = 0; c0 = 0; b1 = 0; b0 = 0;
        for (int k = 1; k <= 200; k++) begin
            start = (k == restart_at);
            @(posedge clk); #1;
            if (peak_valid1) begin c1++; if (l1 < 0) l1 = k; end
            if (peak_valid0) begin c0++; if (l0 < 0) l0 = k; end
            if (busy1) b1++;
            if (busy0) b0++;
        end
        start = 1'b0;
    endtask

    task automatic check_ramp(input string tag);
        chk({tag, "_peak_value1"}, peak_value1, 32'h42FE0000);
        chk({tag, "_peak_index1"}, 32'(peak_index1), 32'd127);
        chk({tag, "_above1"}, 32'(above_count1), 32'd27);
        chk({tag, "_nan1"}, 32'(nan_count1), 32'd0);
        chk({tag, "_peak_value0"}, peak_value0, 32'h42FE0000);
        chk({tag, "_peak_index0"}, 32'(peak_index0), 32'd127);
        chk({tag, "_above0"}, 32'(above_count0), 32'd27);
    endtask

    initial begin
        int l1, l0, c1, c0, b1, b0;
        n_reset   = 1'b0;
        start     = 1'b0;
        dft_done  = 1'b1;
        thresh_in = 32'h0;
        clear_mem();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_ampl_number", 32'(ampl_number1), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_peak_valid", 32'(peak_valid1), 32'd0);
        chk("rst_abort", 32'(abort1), 32'd0);
        chk("rst_peak_value", peak_value1, 32'd0);
        chk("rst_peak_index", 32'(peak_index1), 32'd0);
        chk("rst_above", 32'(above_count1), 32'd0);
        chk("rst_nan", 32'(nan_count1), 32'd0);

        // Start gating: dft_done low blocks the scan
        dft_done = 1'b0;
        do_start();
        chk("gate_busy1", 32'(busy1), 32'd0);
        chk("gate_busy0", 32'(busy0), 32'd0);
        @(posedge clk); #1;
        chk("gate_busy_later", 32'(busy1), 32'd0);
        dft_done = 1'b1;

        // Ramp with a repeated start mid-scan
        load_ramp();
        thresh_in = 32'h42C80000;
        do_start();
        chk("ramp_busy_e0", 32'(busy1), 32'd1);
        chk("ramp_addr_e0", 32'(ampl_number1), 32'd1);
        chk("ramp_addr0_e0", 32'(ampl_number0), 32'd0);
        run_scan(50, l1, l0, c1, c0, b1, b0);
        chk("ramp_latency1", l1, 32'd128);
        chk("ramp_latency0", l0, 32'd129);
        chk("ramp_pulses1", c1, 32'd1);
        chk("ramp_pulses0", c0, 32'd1);
        chk("ramp_busy_cycles1", b1, 32'd127);
        chk("ramp_busy_cycles0", b0, 32'd128);
        check_ramp("ramp");

        // DC dominant
        clear_mem();
        mem[0] = 32'h447A0000;
        mem[5] = 32'h40400000;
        do_start();
        run_scan(0, l1, l0, c1, c0, b1, b0);
        chk("dc_pulses1", c1, 32'd1);
        chk("dc_peak_index1", 32'(peak_index1), 32'd5);
        chk("dc_peak_value1", peak_value1, 32'h40400000);
        chk("dc_above1", 32'(above_count1), 32'd0);
        chk("dc_peak_index0", 32'(peak_index0), 32'd0);
        chk("dc_peak_value0", peak_value0, 32'h447A0000);
        chk("dc_above0", 32'(above_count0), 32'd1);

        // Ties, NaN, negative bin, negative threshold (sign ignored -> 4.0)
        clear_mem();
        mem[10] = 32'h41000000;
        mem[20] = 32'h41000000;
        mem[30] = 32'h7FC00000;
        mem[40] = 32'hC2480000;
        thresh_in = 32'hC0800000;
        do_start();
        run_scan(0, l1, l0, c1, c0, b1, b0);
        chk("tie_peak_index1", 32'(peak_index1), 32'd10);
        chk("tie_peak_value1", peak_value1, 32'h41000000);
        chk("tie_nan1", 32'(nan_count1), 32'd1);
        chk("tie_above1", 32'(above_count1), 32'd2);
        chk("tie_peak_index0", 32'(peak_index0), 32'd10);
        chk("tie_nan0", 32'(nan_count0), 32'd1);
`ifdef DFT_PEAK_TOP2_EN
        chk("tie_second_index1", 32'(second_index1), 32'd20);
        chk("tie_second_value1", second_value1, 32'h41000000);
`endif

        // Abort: dft_done drops after E40, seen at E41
        load_ramp();
        do_start();
        repeat (40) @(posedge clk);
        #1;
        chk("abort_busy_e40", 32'(busy1), 32'd1);
        dft_done = 1'b0;
        @(posedge clk); #1;
        chk("abort_pulse1", 32'(abort1), 32'd1);
        chk("abort_pulse0", 32'(abort0), 32'd1);
        chk("abort_busy1", 32'(busy1), 32'd0);
        chk("abort_no_valid", 32'(peak_valid1), 32'd0);
        @(posedge clk); #1;
        chk("abort_one_cycle", 32'(abort1), 32'd0);
        chk("abort_keep_index", 32'(peak_index1), 32'd10);
        chk("abort_keep_nan", 32'(nan_count1), 32'd1);
        chk("abort_keep_above", 32'(above_count1), 32'd2);
        dft_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_still_no_valid", 32'(peak_valid1), 32'd0);

        // Async reset mid-scan
        thresh_in = 32'h42C80000;
        do_start();
        repeat (60) @(posedge clk);
        #1;
        n_reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy1), 32'd0);
        chk("mid_rst_addr", 32'(ampl_number1), 32'd0);
        chk("mid_rst_peak_index", 32'(peak_index1), 32'd0);
        chk("mid_rst_peak_value", peak_value1, 32'd0);
        chk("mid_rst_nan", 32'(nan_count1), 32'd0);
        chk("mid_rst_above", 32'(above_count1), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk); #1;
        do_start();
        run_scan(0, l1, l0, c1, c0, b1, b0);
        chk("post_rst_latency1", l1, 32'd128);
        check_ramp("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
